zcash_axi_lite_router: RTL and testbench
========================================

# zcash_axi_lite_router

Single-master, two-target AXI-lite transaction router and arbiter for the OCL control path. It sits between the AWS OCL AXI-lite sink and two targets: the zcash control register space and the AXI-stream FIFO control space. It serialises reads and writes one at a time, alternating between them, and decodes the address into a region. Unmapped accesses get DECERR; a target that does not respond gets SLVERR after a timeout.

## Interface
- A_BITS, 32, address width of all three AXI-lite interfaces.
- ZCASH_OFFSET, 32'h0000_0000, base of the zcash region.
- FIFO_OFFSET, 32'h0000_1000, base of the FIFO region.
- REGION_SIZE, 32'h0000_1000, size of each region in bytes.
- TIMEOUT_CYCLES, 1024, cycles allowed from entering FWD until the target responds.

- i_clk  in  1  clock; the only clock.
- i_rst  in  1  synchronous, active-high reset.
- rx_axi_lite_if  if_axi_lite.sink  A_BITS  upstream master (OCL).
- zcash_axi_lite_if  if_axi_lite.source  A_BITS  zcash target; address presented as addr − ZCASH_OFFSET.
- fifo_axi_lite_if  if_axi_lite.source  A_BITS  FIFO target; address presented as addr − FIFO_OFFSET.
- o_busy  out  1  high whenever state ≠ IDLE.
- o_dec_err  out  1  one-cycle pulse when an unmapped access is decoded.
- o_timeout  out  1  one-cycle pulse when a target times out.

## Operation
**States:** IDLE, FWD, WAIT, RESP.

**IDLE**
- A write is pending when awvalid && wvalid. A read is pending when arvalid.
- Only one transaction is granted per visit to IDLE.
- Grant rule: if only one kind is pending, grant it. If both are pending, grant the kind not granted last.
- The last-grant register resets to "read", so the first contested grant goes to the write.
- Write grant: awready = wready = 1 for that cycle; capture awaddr, wdata, wstrb.
- Read grant: arready = 1 for that cycle; capture araddr.
- awready/wready depending on both valids is legal AXI-lite slave behaviour.

**Decode (on the captured address)**
- Hit means ZCASH_OFFSET ≤ addr < ZCASH_OFFSET+REGION_SIZE (same rule for FIFO_OFFSET).
- zcash hit → target zcash. FIFO hit → target FIFO.
- No hit → skip FWD/WAIT, go to RESP with resp = 2'b11, rdata = 0, and pulse o_dec_err.
- Target marked hung → go to RESP with resp = 2'b10; no timeout pulse.

**FWD**
- Write: drive target awvalid and wvalid with the translated address, wdata and wstrb.
- Each valid drops independently on its own ready.
- Read: drive target arvalid until arready.
- Move to WAIT once all address/data handshakes are complete.

**WAIT**
- Hold bready (write) or rready (read) high to the target.
- On bvalid or rvalid, capture bresp or rresp/rdata, then go to RESP.

**RESP**
- Drive rx bvalid with captured bresp, or rx rvalid with rresp/rdata.
- Hold until the master's bready/rready, then return to IDLE.

**Timeout**
- Counter width $clog2(TIMEOUT_CYCLES+1). Cleared on entering FWD; increments every cycle in FWD and WAIT.
- When the counter reaches TIMEOUT_CYCLES:
  - deassert all target valids;
  - set that target's hung flag;
  - pulse o_timeout;
  - go to RESP with resp = 2'b10 and rdata = 32'hDEAD_0000.

**Hung target**
- bready and rready to that target are held high, outside the active transaction, to drain late responses.
- The first bvalid or rvalid received clears the hung flag; the response is discarded.
- Only an explicit i_rst clears the hung flags otherwise.

## Timing
- Reset values: all rx readies 0, bvalid/rvalid 0, bresp/rresp 0, rdata 0.
- Reset values: all target valids 0, target bready/rready 0.
- Reset values: state IDLE, counter 0, hung flags 0, o_busy/o_dec_err/o_timeout 0, last-grant = read.
- Mapped write, target ready immediately:
  - cycle 0: grant;
  - cycle 1: target aw/wvalid;
  - cycle 2 at earliest: target bvalid;
  - following cycle: rx bvalid.
- Minimum mapped latency is grant + 3 cycles.
- Decode error: rx bvalid/rvalid in the cycle after the grant.
- A response arriving in the same cycle the counter reaches TIMEOUT_CYCLES wins: normal response, no timeout.
- Reset mid-transaction: return to IDLE next cycle. All valids drop and no response is issued. Hung flags are cleared.
- Master-facing channels never have more than one outstanding transaction. Target responses are never forwarded combinationally.

## Test plan
- Write addr 0x0004, data 0xA5A5_A5A5 → zcash sees awaddr 0x0004, wdata 0xA5A5_A5A5. Master gets bresp 0 three cycles after the grant when the target is zero-wait.
- Read addr 0x1008 → FIFO sees araddr 0x0008. The master's rdata equals the target's returned 0x1234_5678, with rresp 0.
- Read addr 0x4000 → rvalid one cycle after arready, rresp 2'b11, rdata 0, o_dec_err pulses once.
- Write and read asserted together out of reset, repeated 4 times → grant order W, R, W, R, W, R, W, R.
- TIMEOUT_CYCLES = 16, zcash never asserts bvalid:
  - bresp 2'b10 arrives 16 cycles after FWD entry, and o_timeout pulses.
  - A next write to zcash returns 2'b10 immediately.
  - A late bvalid from zcash clears hung; a following write completes with bresp 0.
- Assert i_rst while in WAIT → all outputs at reset values next cycle. A subsequent transaction completes normally.

Source files
------------

// File: rtl/zcash_axi_lite_router_if.sv
// if_axi_lite: AXI-lite bus bundle; source drives requests, sink answers them
interface if_axi_lite #(parameter int A_BITS = 32) ();
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [A_BITS-1:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;
    modport source (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport sink (
        input awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/zcash_axi_lite_router.sv
// zcash_axi_lite_router: serialising AXI-lite router from OCL to the zcash and FIFO register targets
module zcash_axi_lite_router #(
    parameter int A_BITS = 32,
    parameter logic [A_BITS-1:0] ZCASH_OFFSET = 32'h0000_0000,
    parameter logic [A_BITS-1:0] FIFO_OFFSET = 32'h0000_1000,
    parameter logic [A_BITS-1:0] REGION_SIZE = 32'h0000_1000,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst,
    if_axi_lite.sink   rx_axi_lite_if,
    if_axi_lite.source zcash_axi_lite_if,
    if_axi_lite.source fifo_axi_lite_if,
    output logic       o_busy,
    output logic       o_dec_err,
    output logic       o_timeout
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, FWD, WAIT, RESP} state_t;
    state_t state;
    logic is_wr, tgt, last_w, aw_v, w_v, ar_v, rx_b, rx_r;
    logic [1:0] hung, resp;
    logic [A_BITS-1:0] taddr, g_addr;
    logic [31:0] wdata, rdata, t_rdata;
    logic [3:0] wstrb;
    logic [CW-1:0] cnt;
    logic gnt_w, gnt_r, z_hit, f_hit, t_awready, t_wready, t_arready, rsp_hs, expire, fwd_done;
    logic [1:0] t_resp;
    always_comb begin
        gnt_w = state == IDLE && rx_axi_lite_if.awvalid && rx_axi_lite_if.wvalid && (!rx_axi_lite_if.arvalid || !last_w);
        gnt_r = state == IDLE && rx_axi_lite_if.arvalid && !gnt_w;
        g_addr = gnt_w ? rx_axi_lite_if.awaddr : rx_axi_lite_if.araddr;
        // unsigned wrap makes addresses below the base fail the compare too
        z_hit = (g_addr - ZCASH_OFFSET) < REGION_SIZE;
        f_hit = (g_addr - FIFO_OFFSET) < REGION_SIZE;
        t_awready = tgt ? fifo_axi_lite_if.awready : zcash_axi_lite_if.awready;
        t_wready = tgt ? fifo_axi_lite_if.wready : zcash_axi_lite_if.wready;
        t_arready = tgt ? fifo_axi_lite_if.arready : zcash_axi_lite_if.arready;
        t_rdata = tgt ? fifo_axi_lite_if.rdata : zcash_axi_lite_if.rdata;
        t_resp = tgt ? (is_wr ? fifo_axi_lite_if.bresp : fifo_axi_lite_if.rresp)
                     : (is_wr ? zcash_axi_lite_if.bresp : zcash_axi_lite_if.rresp);
        rsp_hs = state == WAIT && (tgt ? (is_wr ? fifo_axi_lite_if.bvalid : fifo_axi_lite_if.rvalid)
                                       : (is_wr ? zcash_axi_lite_if.bvalid : zcash_axi_lite_if.rvalid));
        expire = cnt == CW'(TIMEOUT_CYCLES - 1);
        fwd_done = (!aw_v || t_awready) && (!w_v || t_wready) && (!ar_v || t_arready);
    end
    assign o_busy = state != IDLE;
    assign rx_axi_lite_if.awready = gnt_w;
    assign rx_axi_lite_if.wready = gnt_w;
    assign rx_axi_lite_if.arready = gnt_r;
    assign rx_axi_lite_if.bvalid = rx_b;
    assign rx_axi_lite_if.rvalid = rx_r;
    assign rx_axi_lite_if.bresp = resp;
    assign rx_axi_lite_if.rresp = resp;
    assign rx_axi_lite_if.rdata = rdata;
    assign zcash_axi_lite_if.awvalid = aw_v && !tgt;
    assign zcash_axi_lite_if.wvalid = w_v && !tgt;
    assign zcash_axi_lite_if.arvalid = ar_v && !tgt;
    assign zcash_axi_lite_if.awaddr = taddr;
    assign zcash_axi_lite_if.araddr = taddr;
    assign zcash_axi_lite_if.wdata = wdata;
    assign zcash_axi_lite_if.wstrb = wstrb;
    // a hung target keeps its ready high so a late response drains harmlessly
    assign zcash_axi_lite_if.bready = (state == WAIT && is_wr && !tgt) || hung[0];
    assign zcash_axi_lite_if.rready = (state == WAIT && !is_wr && !tgt) || hung[0];
    assign fifo_axi_lite_if.awvalid = aw_v && tgt;
    assign fifo_axi_lite_if.wvalid = w_v && tgt;
    assign fifo_axi_lite_if.arvalid = ar_v && tgt;
    assign fifo_axi_lite_if.awaddr = taddr;
    assign fifo_axi_lite_if.araddr = taddr;
    assign fifo_axi_lite_if.wdata = wdata;
    assign fifo_axi_lite_if.wstrb = wstrb;
    assign fifo_axi_lite_if.bready = (state == WAIT && is_wr && tgt) || hung[1];
    assign fifo_axi_lite_if.rready = (state == WAIT && !is_wr && tgt) || hung[1];
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            {is_wr, tgt, last_w, aw_v, w_v, ar_v, rx_b, rx_r, o_dec_err, o_timeout} <= '0;
            hung <= '0;
            resp <= '0;
            taddr <= '0;
            wdata <= '0;
            rdata <= '0;
            wstrb <= '0;
            cnt <= '0;
        end else begin
            o_dec_err <= 1'b0;
            o_timeout <= 1'b0;
            if (hung[0] && (zcash_axi_lite_if.bvalid || zcash_axi_lite_if.rvalid)) hung[0] <= 1'b0;
            if (hung[1] && (fifo_axi_lite_if.bvalid || fifo_axi_lite_if.rvalid)) hung[1] <= 1'b0;
            case (state)
                IDLE: if (gnt_w || gnt_r) begin
                    last_w <= gnt_w;
                    is_wr <= gnt_w;
                    tgt <= !z_hit;
                    taddr <= g_addr - (z_hit ? ZCASH_OFFSET : FIFO_OFFSET);
                    wdata <= rx_axi_lite_if.wdata;
                    wstrb <= rx_axi_lite_if.wstrb;
                    rdata <= '0;
                    cnt <= '0;
                    if (!z_hit && !f_hit) begin
                        state <= RESP;
                        resp <= 2'b11;
                        o_dec_err <= 1'b1;
                        rx_b <= gnt_w;
                        rx_r <= gnt_r;
                    end else if (hung[!z_hit]) begin
                        state <= RESP;
                        resp <= 2'b10;
                        rx_b <= gnt_w;
                        rx_r <= gnt_r;
                    end else begin
                        state <= FWD;
                        aw_v <= gnt_w;
                        w_v <= gnt_w;
                        ar_v <= gnt_r;
                    end
                end
                FWD, WAIT: begin
                    cnt <= cnt + 1'b1;
                    aw_v <= aw_v && !t_awready;
                    w_v <= w_v && !t_wready;
                    ar_v <= ar_v && !t_arready;
                    if (rsp_hs) begin
                        state <= RESP;
                        resp <= t_resp;
                        rdata <= is_wr ? 32'h0 : t_rdata;
                        rx_b <= is_wr;
                        rx_r <= !is_wr;
                    end else if (expire) begin
                        state <= RESP;
                        {aw_v, w_v, ar_v} <= '0;
                        hung[tgt] <= 1'b1;
                        o_timeout <= 1'b1;
                        resp <= 2'b10;
                        rdata <= 32'hDEAD_0000;
                        rx_b <= is_wr;
                        rx_r <= !is_wr;
                    end else if (state == FWD && fwd_done) begin
                        state <= WAIT;
                    end
                end
                RESP: if ((rx_b && rx_axi_lite_if.bready) || (rx_r && rx_axi_lite_if.rready)) begin
                    state <= IDLE;
                    rx_b <= 1'b0;
                    rx_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_zcash_axi_lite_router.sv
// tb_zcash_axi_lite_router: directed scenarios against the router with two simple responder targets
module tb_zcash_axi_lite_router;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, dec_err, timeout;
    logic z_mute = 1'b0;
    logic z_kick = 1'b0;
    logic [31:0] z_awaddr, z_wdata, f_araddr;
    int dec_cnt = 0;
    int to_cnt = 0;
    int tests = 0;
    int fails = 0;
    if_axi_lite #(.A_BITS(32)) rx_if ();
    if_axi_lite #(.A_BITS(32)) z_if ();
    if_axi_lite #(.A_BITS(32)) f_if ();
    zcash_axi_lite_router #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_rst(rst), .rx_axi_lite_if(rx_if), .zcash_axi_lite_if(z_if),
        .fifo_axi_lite_if(f_if), .o_busy(busy), .o_dec_err(dec_err), .o_timeout(timeout)
    );
    always #5 clk = ~clk;
    assign z_if.awready = 1'b1;
    assign z_if.wready = 1'b1;
    assign z_if.arready = 1'b1;
    assign z_if.bresp = 2'b00;
    assign z_if.rresp = 2'b00;
    assign z_if.rdata = 32'hCAFE_0000;
    assign f_if.awready = 1'b1;
    assign f_if.wready = 1'b1;
    assign f_if.arready = 1'b1;
    assign f_if.bresp = 2'b00;
    assign f_if.rresp = 2'b00;
    always @(posedge clk) begin
        dec_cnt <= dec_cnt + int'(dec_err);
        to_cnt <= to_cnt + int'(timeout);
        if (z_if.awvalid && z_if.awready) begin
            z_awaddr <= z_if.awaddr;
            z_wdata <= z_if.wdata;
        end
        if (rst) z_if.bvalid <= 1'b0;
        else if (z_if.bvalid && z_if.bready) z_if.bvalid <= 1'b0;
        else if (z_kick || (z_if.awvalid && z_if.awready && !z_mute)) z_if.bvalid <= 1'b1;
        if (rst) z_if.rvalid <= 1'b0;
        else if (z_if.rvalid && z_if.rready) z_if.rvalid <= 1'b0;
        else if (z_if.arvalid && z_if.arready) z_if.rvalid <= 1'b1;
    end
    always @(posedge clk) begin
        if (f_if.arvalid && f_if.arready) f_araddr <= f_if.araddr;
        if (rst) f_if.bvalid <= 1'b0;
        else if (f_if.bvalid && f_if.bready) f_if.bvalid <= 1'b0;
        else if (f_if.awvalid && f_if.awready) f_if.bvalid <= 1'b1;
        if (rst) f_if.rvalid <= 1'b0;
        else if (f_if.rvalid && f_if.rready) f_if.rvalid <= 1'b0;
        else if (f_if.arvalid && f_if.arready) f_if.rvalid <= 1'b1;
        if (rst) f_if.rdata <= 32'h0;
        else if (f_if.arvalid && f_if.arready) f_if.rdata <= 32'h1234_5678;
    end
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask
    // lat counts cycles from the grant cycle to the response cycle; -1 means no response arrived
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] r, output int lat);
        int n = 0;
        rx_if.awaddr = a;
        rx_if.wdata = d;
        rx_if.wstrb = 4'hF;
        rx_if.awvalid = 1'b1;
        rx_if.wvalid = 1'b1;
        rx_if.bready = 1'b1;
        #1;
        while (!rx_if.awready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        rx_if.awvalid = 1'b0;
        rx_if.wvalid = 1'b0;
        lat = 1;
        while (!rx_if.bvalid && lat < 100) begin @(posedge clk); #1; lat++; end
        r = rx_if.bresp;
        if (lat >= 100) lat = -1;
        @(posedge clk); #1;
        rx_if.bready = 1'b0;
    endtask
    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r, output int lat);
        int n = 0;
        rx_if.araddr = a;
        rx_if.arvalid = 1'b1;
        rx_if.rready = 1'b1;
        #1;
        while (!rx_if.arready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        rx_if.arvalid = 1'b0;
        lat = 1;
        while (!rx_if.rvalid && lat < 100) begin @(posedge clk); #1; lat++; end
        r = rx_if.rresp;
        d = rx_if.rdata;
        if (lat >= 100) lat = -1;
        @(posedge clk); #1;
        rx_if.rready = 1'b0;
    endtask
    task automatic test_reset();
        do_reset();
        tests++; if ({rx_if.awready, rx_if.wready, rx_if.arready} !== 3'b000) begin fails++; $display("FAIL reset_readies: got %b expected 000", {rx_if.awready, rx_if.wready, rx_if.arready}); end
        tests++; if ({rx_if.bvalid, rx_if.rvalid, rx_if.bresp, rx_if.rdata} !== 36'h0) begin fails++; $display("FAIL reset_rx_resp: got %h expected 0", {rx_if.bvalid, rx_if.rvalid, rx_if.bresp, rx_if.rdata}); end
        tests++; if ({z_if.awvalid, z_if.wvalid, z_if.arvalid, z_if.bready, z_if.rready, f_if.awvalid, f_if.arvalid, f_if.bready, f_if.rready} !== 9'h0) begin fails++; $display("FAIL reset_target: got %b expected 0", {z_if.awvalid, z_if.wvalid, z_if.arvalid, z_if.bready, z_if.rready, f_if.awvalid, f_if.arvalid, f_if.bready, f_if.rready}); end
        tests++; if ({busy, dec_err, timeout} !== 3'b000) begin fails++; $display("FAIL reset_status: got %b expected 000", {busy, dec_err, timeout}); end
    endtask
    task automatic test_write();
        logic [1:0] r;
        int lat;
        do_write(32'h0000_0004, 32'hA5A5_A5A5, r, lat);
        tests++; if (z_awaddr !== 32'h4) begin fails++; $display("FAIL wr_awaddr: got %h expected 00000004", z_awaddr); end
        tests++; if (z_wdata !== 32'hA5A5_A5A5) begin fails++; $display("FAIL wr_wdata: got %h expected a5a5a5a5", z_wdata); end
        tests++; if (r !== 2'b00) begin fails++; $display("FAIL wr_bresp: got %b expected 00", r); end
        tests++; if (lat !== 3) begin fails++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    endtask
    task automatic test_read();
        logic [31:0] d;
        logic [1:0] r;
        int lat;
        do_read(32'h0000_1008, d, r, lat);
        tests++; if (f_araddr !== 32'h8) begin fails++; $display("FAIL rd_araddr: got %h expected 00000008", f_araddr); end
        tests++; if (d !== 32'h1234_5678) begin fails++; $display("FAIL rd_rdata: got %h expected 12345678", d); end
        tests++; if (r !== 2'b00) begin fails++; $display("FAIL rd_rresp: got %b expected 00", r); end
        tests++; if (lat !== 3) begin fails++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    endtask
    task automatic test_dec_err();
        logic [31:0] d;
        logic [1:0] r;
        int lat;
        int d0 = dec_cnt;
        do_read(32'h0000_4000, d, r, lat);
        tests++; if (lat !== 1) begin fails++; $display("FAIL dec_latency: got %0d expected 1", lat); end
        tests++; if (r !== 2'b11) begin fails++; $display("FAIL dec_rresp: got %b expected 11", r); end
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL dec_rdata: got %h expected 0", d); end
        tests++; if (dec_cnt - d0 !== 1) begin fails++; $display("FAIL dec_pulse: got %0d expected 1", dec_cnt - d0); end
    endtask
    task automatic test_back_to_back();
        logic [7:0] seq = 8'h0;
        int g = 0;
        int n = 0;
        do_reset();
        rx_if.awaddr = 32'h0;
        rx_if.wdata = 32'h1;
        rx_if.araddr = 32'h1000;
        {rx_if.awvalid, rx_if.wvalid, rx_if.arvalid, rx_if.bready, rx_if.rready} = 5'b11111;
        #1;
        while (g < 8 && n < 200) begin
            if (rx_if.awready) begin seq = {seq[6:0], 1'b1}; g++; end
            else if (rx_if.arready) begin seq = {seq[6:0], 1'b0}; g++; end
            @(posedge clk); #1;
            n++;
        end
        {rx_if.awvalid, rx_if.wvalid, rx_if.arvalid} = 3'b000;
        repeat (8) @(posedge clk);
        #1 {rx_if.bready, rx_if.rready} = 2'b00;
        tests++; if (seq !== 8'b1010_1010 || g !== 8) begin fails++; $display("FAIL grant_order: got %b (%0d grants) expected 10101010", seq, g); end
    endtask
    task automatic test_timeout();
        logic [1:0] r;
        int lat;
        int t0 = to_cnt;
        z_mute = 1'b1;
        do_write(32'h0000_0010, 32'h5, r, lat);
        tests++; if (lat !== 17) begin fails++; $display("FAIL to_latency: got %0d expected 17", lat); end
        tests++; if (r !== 2'b10) begin fails++; $display("FAIL to_bresp: got %b expected 10", r); end
        tests++; if (to_cnt - t0 !== 1) begin fails++; $display("FAIL to_pulse: got %0d expected 1", to_cnt - t0); end
        tests++; if (z_if.bready !== 1'b1) begin fails++; $display("FAIL hung_drain_ready: got %b expected 1", z_if.bready); end
        do_write(32'h0000_0014, 32'h6, r, lat);
        tests++; if (r !== 2'b10 || lat !== 1) begin fails++; $display("FAIL hung_fast: got resp %b lat %0d expected 10 lat 1", r, lat); end
        tests++; if (to_cnt - t0 !== 1) begin fails++; $display("FAIL hung_no_pulse: got %0d expected 1", to_cnt - t0); end
        z_kick = 1'b1;
        @(posedge clk); #1;
        z_kick = 1'b0;
        @(posedge clk); #1;
        tests++; if (z_if.bready !== 1'b0) begin fails++; $display("FAIL hung_cleared: got %b expected 0", z_if.bready); end
        z_mute = 1'b0;
        do_write(32'h0000_0008, 32'h7, r, lat);
        tests++; if (r !== 2'b00 || lat !== 3) begin fails++; $display("FAIL post_hung_wr: got resp %b lat %0d expected 00 lat 3", r, lat); end
    endtask
    task automatic test_mid_reset();
        logic [1:0] r;
        int lat;
        int n = 0;
        logic seen = 1'b0;
        z_mute = 1'b1;
        rx_if.awaddr = 32'h20;
        rx_if.wdata = 32'h9;
        {rx_if.awvalid, rx_if.wvalid, rx_if.bready} = 3'b111;
        #1;
        while (!rx_if.awready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        {rx_if.awvalid, rx_if.wvalid} = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        tests++; if ({busy, z_if.bready} !== 2'b11) begin fails++; $display("FAIL wait_state: got %b expected 11", {busy, z_if.bready}); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++; if ({busy, rx_if.bvalid, z_if.bready, z_if.awvalid, z_if.wvalid} !== 5'b0) begin fails++; $display("FAIL mid_reset: got %b expected 00000", {busy, rx_if.bvalid, z_if.bready, z_if.awvalid, z_if.wvalid}); end
        repeat (20) begin @(posedge clk); #1; seen = seen | rx_if.bvalid; end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL mid_reset_no_resp: got %b expected 0", seen); end
        rx_if.bready = 1'b0;
        z_mute = 1'b0;
        do_write(32'h0000_0024, 32'hB, r, lat);
        tests++; if (r !== 2'b00 || lat !== 3 || z_awaddr !== 32'h24) begin fails++; $display("FAIL post_reset_wr: got resp %b lat %0d addr %h expected 00 lat 3 addr 24", r, lat, z_awaddr); end
    endtask
    initial begin
        {rx_if.awvalid, rx_if.wvalid, rx_if.arvalid, rx_if.bready, rx_if.rready} = 5'b0;
        rx_if.awaddr = 32'h0;
        rx_if.araddr = 32'h0;
        rx_if.wdata = 32'h0;
        rx_if.wstrb = 4'h0;
        test_reset();
        test_write();
        test_read();
        test_dec_err();
        test_back_to_back();
        test_timeout();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
